// File: rtl/spi_pkg.sv
// Shared SPI types: FSM state encoding and the default word width used by both the slave and the master top.
package spi_pkg;
    localparam int SPI_DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;
endpackage

// File: rtl/spi_synchronizer.sv
// Multi-bit flop-chain synchronizer for asynchronous inputs.
// Latency: STAGES clocks. Backpressure: none, free-running.
module spi_synchronizer #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] reset_value,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= reset_value;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four CPOL/CPHA modes, MSB first, oversampled SCLK/CS/MOSI in the i_clock domain.
// Latency: o_rx_valid about SYNC_STAGES+1 clocks after the last raw sample edge.
// Backpressure: one-entry TX holding register (valid/ready); an empty register at word start sends zeros and pulses o_underrun.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_DATA_WIDTH = SPI_DEFAULT_WIDTH,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_clock_polarity,
    input  logic                      i_clock_phase,
    input  logic [SPI_DATA_WIDTH-1:0] i_tx_data,
    input  logic                      i_tx_valid,
    output logic                      o_tx_ready,
    output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
    output logic                      o_rx_valid,
    output logic                      o_underrun,
    input  logic                      i_spi_cs_n,
    input  logic                      i_spi_clock,
    input  logic                      i_spi_mosi,
    output logic                      o_spi_miso,
    output logic                      o_spi_miso_oe
);
    localparam int CNT_W = (SPI_DATA_WIDTH > 2) ? $clog2(SPI_DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_DATA_WIDTH - 1);

    logic [2:0] sync_out;
    logic       cs_s, sclk_s, mosi_s;

    spi_synchronizer #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock       (i_clock),
        .reset_n     (i_reset_n),
        .reset_value ({1'b1, i_clock_polarity, 1'b1}),
        .din         ({i_spi_cs_n, i_spi_clock, i_spi_mosi}),
        .dout        (sync_out)
    );

    assign cs_s   = sync_out[2];
    assign sclk_s = sync_out[1];
    assign mosi_s = sync_out[0];

    spi_state_t                state;
    logic                      cs_d, sclk_d, cpol_l, cpha_l;
    logic [SPI_DATA_WIDTH-1:0] hold_dat, tx_sr, rx_sr, next_word, rx_next;
    logic [CNT_W-1:0]          bit_cnt;
    logic                      need_load;
    logic                      cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic                      leading, trailing, sample_edge, shift_edge;

    assign cs_fall     = cs_d & ~cs_s;
    assign cs_rise     = ~cs_d & cs_s;
    assign sclk_rise   = sclk_s & ~sclk_d;
    assign sclk_fall   = ~sclk_s & sclk_d;
    assign leading     = cpol_l ? sclk_fall : sclk_rise;
    assign trailing    = cpol_l ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_l ? trailing : leading;
    assign shift_edge  = cpha_l ? leading : trailing;
    assign next_word   = o_tx_ready ? '0 : hold_dat;
    assign rx_next     = {rx_sr[SPI_DATA_WIDTH-2:0], mosi_s};

    // tx_sr always holds the bits not yet driven onto MISO, MSB aligned.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            cs_d          <= 1'b1;
            sclk_d        <= i_clock_polarity;
            cpol_l        <= 1'b0;
            cpha_l        <= 1'b0;
            hold_dat      <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            bit_cnt       <= '0;
            need_load     <= 1'b0;
            o_tx_ready    <= 1'b1;
            o_rx_data     <= '0;
            o_rx_valid    <= 1'b0;
            o_underrun    <= 1'b0;
            o_spi_miso    <= 1'b0;
            o_spi_miso_oe <= 1'b0;
        end else begin
            cs_d       <= cs_s;
            sclk_d     <= sclk_s;
            o_rx_valid <= 1'b0;
            o_underrun <= 1'b0;
            if (i_tx_valid && o_tx_ready) begin
                hold_dat   <= i_tx_data;
                o_tx_ready <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state         <= ACTIVE;
                        cpol_l        <= i_clock_polarity;
                        cpha_l        <= i_clock_phase;
                        bit_cnt       <= '0;
                        need_load     <= 1'b0;
                        rx_sr         <= '0;
                        o_spi_miso_oe <= 1'b1;
                        o_underrun    <= o_tx_ready;
                        if (!o_tx_ready) o_tx_ready <= 1'b1;
                        // CPHA=1 waits for the first leading edge to present the MSB.
                        if (i_clock_phase) begin
                            tx_sr      <= next_word;
                            o_spi_miso <= 1'b0;
                        end else begin
                            tx_sr      <= next_word << 1;
                            o_spi_miso <= next_word[SPI_DATA_WIDTH-1];
                        end
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state         <= IDLE;
                        o_spi_miso_oe <= 1'b0;
                        o_spi_miso    <= 1'b0;
                        bit_cnt       <= '0;
                        need_load     <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_sr <= rx_next;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt    <= '0;
                                need_load  <= 1'b1;
                                o_rx_data  <= rx_next;
                                o_rx_valid <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (shift_edge) begin
                            if (need_load) begin
                                need_load  <= 1'b0;
                                tx_sr      <= next_word << 1;
                                o_spi_miso <= next_word[SPI_DATA_WIDTH-1];
                                o_underrun <= o_tx_ready;
                                if (!o_tx_ready) o_tx_ready <= 1'b1;
                            end else begin
                                tx_sr      <= tx_sr << 1;
                                o_spi_miso <= tx_sr[SPI_DATA_WIDTH-1];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Scenario bench for spi_slave: bit-banged SPI master, scoreboard queues for RX words and MISO words.
module tb_spi_slave;
    logic       i_clock = 1'b0;
    logic       i_reset_n;
    logic       i_clock_polarity, i_clock_phase;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid, o_underrun;
    logic       i_spi_cs_n, i_spi_clock, i_spi_mosi;
    logic       o_spi_miso, o_spi_miso_oe;

    int checks = 0;
    int failures = 0;
    int rx_cnt = 0;
    int under_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] mon_exp;

    always #5 i_clock = ~i_clock;

    spi_slave #(.SPI_DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_clock          (i_clock),
        .i_reset_n        (i_reset_n),
        .i_clock_polarity (i_clock_polarity),
        .i_clock_phase    (i_clock_phase),
        .i_tx_data        (i_tx_data),
        .i_tx_valid       (i_tx_valid),
        .o_tx_ready       (o_tx_ready),
        .o_rx_data        (o_rx_data),
        .o_rx_valid       (o_rx_valid),
        .o_underrun       (o_underrun),
        .i_spi_cs_n       (i_spi_cs_n),
        .i_spi_clock      (i_spi_clock),
        .i_spi_mosi       (i_spi_mosi),
        .o_spi_miso       (o_spi_miso),
        .o_spi_miso_oe    (o_spi_miso_oe)
    );

    // RX scoreboard: every o_rx_valid pulse must match the oldest expected word.
    always @(negedge i_clock) begin
        if (i_reset_n) begin
            if (o_underrun) under_cnt++;
            if (o_rx_valid) begin
                rx_cnt++;
                checks++;
                if (rx_q.size() == 0) begin
                    failures++;
                    $display("FAIL rx_unexpected got=%h expected=none", o_rx_data);
                end else begin
                    mon_exp = rx_q.pop_front();
                    if (o_rx_data !== mon_exp) begin
                        failures++;
                        $display("FAIL rx_data got=%h expected=%h", o_rx_data, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        i_clock_polarity = pol;
        i_clock_phase    = pha;
        i_spi_clock      = pol;
        wait_clk(4);
    endtask

    task automatic send_tx(input logic [7:0] d);
        int t = 0;
        while (!o_tx_ready && t < 50) begin
            wait_clk(1);
            t++;
        end
        checks++;
        if (o_tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL tx_ready_wait got=%b expected=1", o_tx_ready);
        end
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        wait_clk(1);
        i_tx_valid = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!i_clock_phase) begin
                i_spi_mosi  = tx[7-i];
                wait_clk(8);
                i_spi_clock = ~i_clock_polarity;
                rx[7-i]     = o_spi_miso;
                wait_clk(8);
                i_spi_clock = i_clock_polarity;
            end else begin
                i_spi_clock = ~i_clock_polarity;
                i_spi_mosi  = tx[7-i];
                wait_clk(8);
                i_spi_clock = i_clock_polarity;
                rx[7-i]     = o_spi_miso;
                wait_clk(8);
            end
        end
    endtask

    task automatic cs_select();
        i_spi_cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_deselect();
        wait_clk(8);
        i_spi_cs_n = 1'b1;
        wait_clk(16);
    endtask

    task automatic check_miso(input string name, input logic [7:0] got);
        logic [7:0] exp;
        checks++;
        if (miso_q.size() == 0) begin
            failures++;
            $display("FAIL %s got=%h expected=none", name, got);
        end else begin
            exp = miso_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", name, got, exp);
            end
        end
    endtask

    task automatic check_rx_count(input string name, input int got, input int exp);
        checks++;
        if (got !== exp || rx_q.size() != 0) begin
            failures++;
            $display("FAIL %s got=%0d pending=%0d expected=%0d pending=0", name, got, rx_q.size(), exp);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_spi_cs_n = 1'b1; i_spi_mosi = 1'b0; i_tx_valid = 1'b0; i_tx_data = '0;
        i_clock_polarity = 1'b0; i_clock_phase = 1'b0; i_spi_clock = 1'b0;
        wait_clk(3);
        checks++;
        if ({o_tx_ready, o_rx_data, o_rx_valid, o_underrun, o_spi_miso, o_spi_miso_oe} !== 13'b1_00000000_0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=%b",
                     {o_tx_ready, o_rx_data, o_rx_valid, o_underrun, o_spi_miso, o_spi_miso_oe}, 13'b1_00000000_0000);
        end
        i_reset_n = 1'b1;
        wait_clk(4);
        checks++;
        if ({o_tx_ready, o_spi_miso_oe} !== 2'b10) begin
            failures++;
            $display("FAIL idle_after_reset got=%b expected=10", {o_tx_ready, o_spi_miso_oe});
        end
    endtask

    task automatic test_modes();
        logic [7:0] rxb;
        int r0;
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0]);
            r0 = rx_cnt;
            send_tx(8'h69);
            miso_q.push_back(8'h69);
            rx_q.push_back(8'h96);
            cs_select();
            xfer(8'h96, 8, rxb);
            cs_deselect();
            check_miso($sformatf("mode%0d_miso", m), rxb);
            check_rx_count($sformatf("mode%0d_rx_pulses", m), rx_cnt - r0, 1);
            checks++;
            if (o_rx_data !== 8'h96) begin
                failures++;
                $display("FAIL mode%0d_rx_hold got=%h expected=96", m, o_rx_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rxb;
        int r0;
        set_mode(1'b0, 1'b0);
        r0 = rx_cnt;
        send_tx(8'hA5);
        miso_q.push_back(8'hA5); miso_q.push_back(8'h3C);
        rx_q.push_back(8'h11);   rx_q.push_back(8'h22);
        i_spi_cs_n = 1'b0;
        send_tx(8'h3C);
        xfer(8'h11, 8, rxb);
        check_miso("b2b_miso_word0", rxb);
        xfer(8'h22, 8, rxb);
        check_miso("b2b_miso_word1", rxb);
        cs_deselect();
        check_rx_count("b2b_rx_pulses", rx_cnt - r0, 2);
    endtask

    task automatic test_underrun();
        logic [7:0] rxb;
        int u0;
        set_mode(1'b0, 1'b1);
        u0 = under_cnt;
        miso_q.push_back(8'h00);
        rx_q.push_back(8'h5C);
        cs_select();
        checks++;
        if (o_spi_miso_oe !== 1'b1) begin
            failures++;
            $display("FAIL underrun_oe got=%b expected=1", o_spi_miso_oe);
        end
        xfer(8'h5C, 8, rxb);
        cs_deselect();
        check_miso("underrun_miso", rxb);
        checks++;
        if (under_cnt - u0 !== 1) begin
            failures++;
            $display("FAIL underrun_pulses got=%0d expected=1", under_cnt - u0);
        end
    endtask

    task automatic test_abort();
        logic [7:0] rxb;
        int r0;
        set_mode(1'b0, 1'b0);
        r0 = rx_cnt;
        send_tx(8'hC3);
        cs_select();
        xfer(8'hFF, 5, rxb);
        checks++;
        if (rxb[7:3] !== 5'b11000) begin
            failures++;
            $display("FAIL abort_partial_miso got=%b expected=11000", rxb[7:3]);
        end
        i_spi_cs_n = 1'b1;
        wait_clk(4);
        checks++;
        if (o_spi_miso_oe !== 1'b0) begin
            failures++;
            $display("FAIL abort_oe got=%b expected=0", o_spi_miso_oe);
        end
        wait_clk(16);
        check_rx_count("abort_no_rx", rx_cnt - r0, 0);
        send_tx(8'h7E);
        miso_q.push_back(8'h7E);
        rx_q.push_back(8'hE7);
        cs_select();
        xfer(8'hE7, 8, rxb);
        cs_deselect();
        check_miso("abort_next_miso", rxb);
        check_rx_count("abort_next_rx", rx_cnt - r0, 1);
    endtask

    task automatic test_handshake();
        logic [7:0] rxb;
        int t;
        set_mode(1'b1, 1'b1);
        i_tx_data  = 8'h55;
        i_tx_valid = 1'b1;
        wait_clk(1);
        checks++;
        if (o_tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL hs_ready_fall got=%b expected=0", o_tx_ready);
        end
        i_tx_data = 8'hAA;
        wait_clk(5);
        checks++;
        if (o_tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL hs_ready_held got=%b expected=0", o_tx_ready);
        end
        miso_q.push_back(8'h55);
        rx_q.push_back(8'h3A);
        i_spi_cs_n = 1'b0;
        t = 0;
        while (!o_tx_ready && t < 10) begin
            wait_clk(1);
            t++;
        end
        checks++;
        if (o_tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL hs_ready_rise got=%b expected=1", o_tx_ready);
        end
        wait_clk(1);
        i_tx_valid = 1'b0;
        checks++;
        if (o_tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL hs_second_accept got=%b expected=0", o_tx_ready);
        end
        wait_clk(4);
        xfer(8'h3A, 8, rxb);
        cs_deselect();
        check_miso("hs_miso_first", rxb);
        miso_q.push_back(8'hAA);
        rx_q.push_back(8'hC5);
        cs_select();
        xfer(8'hC5, 8, rxb);
        cs_deselect();
        check_miso("hs_miso_second", rxb);
    endtask

    task automatic test_reset_mid();
        logic [7:0] rxb;
        int r0;
        set_mode(1'b0, 1'b1);
        r0 = rx_cnt;
        send_tx(8'h81);
        cs_select();
        send_tx(8'h99);
        xfer(8'hF0, 3, rxb);
        #2 i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_tx_ready, o_rx_data, o_rx_valid, o_underrun, o_spi_miso, o_spi_miso_oe} !== 13'b1_00000000_0000) begin
            failures++;
            $display("FAIL reset_async got=%b expected=%b",
                     {o_tx_ready, o_rx_data, o_rx_valid, o_underrun, o_spi_miso, o_spi_miso_oe}, 13'b1_00000000_0000);
        end
        i_spi_cs_n  = 1'b1;
        i_spi_clock = 1'b0;
        wait_clk(3);
        i_reset_n = 1'b1;
        wait_clk(4);
        send_tx(8'h42);
        miso_q.push_back(8'h42);
        rx_q.push_back(8'h24);
        cs_select();
        xfer(8'h24, 8, rxb);
        cs_deselect();
        check_miso("post_reset_miso", rxb);
        check_rx_count("post_reset_rx", rx_cnt - r0, 1);
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_handshake();
        test_reset_mid();
        checks++;
        if (rx_q.size() != 0 || miso_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d/%0d expected=0/0", rx_q.size(), miso_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
